frame_draw_scheduler: RTL and testbench



---
 rtl/types_pkg.sv | 35 +++
 rtl/frame_draw_scheduler_fb_write_mux.sv | 58 +++++
 rtl/frame_draw_scheduler.sv | 143 ++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types for the frame draw scheduler
//
// Purpose: pixel colour type, scheduler FSM states and write-port owner
// encoding, plus the state-to-owner mapping used by the top level.
// Ports: none (package).
package types_pkg;

  typedef logic [15:0] color_t;

  typedef enum logic [2:0] {
    IDLE,
    BG_START,
    BG_WAIT,
    SH_START,
    SH_WAIT,
    DRAIN,
    SWAP
  } sched_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BG,
    SRC_SHAPE
  } draw_src_t;

  // A drawer owns the frame-buffer port from its start cycle through its done cycle.
  function automatic draw_src_t owner_of(input sched_state_t s);
    case (s)
      BG_START, BG_WAIT: return SRC_BG;
      SH_START, SH_WAIT: return SRC_SHAPE;
      default:           return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_fb_write_mux.sv
// rtl/frame_draw_scheduler_fb_write_mux.sv - registered frame-buffer write selector
//
// Purpose: forwards the write stream of the current owner to the frame-buffer
// port with one cycle of latency; writes from the other stream are dropped.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   src                               current owner (SRC_NONE drops everything)
//   bg_write_en/addr/data             background drawer stream
//   shape_write_en/addr/data          shape drawer stream
//   fb_write_en/addr/data             registered frame-buffer write port
module fb_write_mux
  import types_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  draw_src_t         src,
  input  logic              bg_write_en,
  input  logic [ADDR_W-1:0] bg_write_addr,
  input  color_t            bg_write_data,
  input  logic              shape_write_en,
  input  logic [ADDR_W-1:0] shape_write_addr,
  input  color_t            shape_write_data,
  output logic              fb_write_en,
  output logic [ADDR_W-1:0] fb_write_addr,
  output color_t            fb_write_data
);

  // Address/data only load on an accepted write so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_write_en   <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
    end else begin
      fb_write_en <= 1'b0;
      case (src)
        SRC_BG: begin
          fb_write_en <= bg_write_en;
          if (bg_write_en) begin
            fb_write_addr <= bg_write_addr;
            fb_write_data <= bg_write_data;
          end
        end
        SRC_SHAPE: begin
          fb_write_en <= shape_write_en;
          if (shape_write_en) begin
            fb_write_addr <= shape_write_addr;
            fb_write_data <= shape_write_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - sequences background and shape drawers for one frame
//
// Purpose: on frame_start runs the background drawer, then the shape drawer
// once per shape index, waits one drain cycle for the last registered write,
// then handshakes a buffer swap. Owns the single frame-buffer write port.
// Optional build macro: FRAME_OVERRUN_COUNT_EN enables the dropped
// frame_start counter; without it overrun_count is tied to zero.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   frame_start, shape_count          frame request and shape count (clamped)
//   busy, frame_done                  status; frame_done pulses on swap_ack
//   bg_start, bg_done, bg_write_*     background drawer control and stream
//   shape_start, shape_idx,
//   shape_done, shape_write_*         shape drawer control and stream
//   fb_write_*                        registered frame-buffer write port
//   swap_req, swap_ack                buffer swap handshake
//   overrun_count                     frame_start requests seen while busy
module frame_draw_scheduler
  import types_pkg::*;
#(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int MAX_SHAPES        = 16,
  parameter int CNT_W             = $clog2(MAX_SHAPES + 1),
  parameter int IDX_W             = $clog2(MAX_SHAPES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [CNT_W-1:0]             shape_count,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         bg_start,
  input  logic                         bg_done,
  input  logic                         bg_write_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] bg_write_addr,
  input  color_t                       bg_write_data,
  output logic                         shape_start,
  output logic [IDX_W-1:0]             shape_idx,
  input  logic                         shape_done,
  input  logic                         shape_write_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] shape_write_addr,
  input  color_t                       shape_write_data,
  output logic                         fb_write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] fb_write_addr,
  output color_t                       fb_write_data,
  output logic                         swap_req,
  input  logic                         swap_ack,
  output logic [15:0]                  overrun_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHAPES);

  sched_state_t     state;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx;
  logic             last_shape;

  // Only evaluated in shape states, where count_q is known to be non-zero.
  assign last_shape = (CNT_W'(idx) == count_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            count_q <= (shape_count > MAX_CNT) ? MAX_CNT : shape_count;
            idx     <= '0;
            state   <= BG_START;
          end
        end
        BG_START: state <= BG_WAIT;
        BG_WAIT: begin
          if (bg_done) state <= (count_q != '0) ? SH_START : DRAIN;
        end
        SH_START: state <= SH_WAIT;
        SH_WAIT: begin
          if (shape_done) begin
            if (last_shape) begin
              state <= DRAIN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= SH_START;
            end
          end
        end
        DRAIN: state <= SWAP;
        SWAP: begin
          if (swap_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs are straight decodes of the state register; frame_done
  // has to follow swap_ack in the same cycle.
  assign busy        = (state != IDLE);
  assign bg_start    = (state == BG_START);
  assign shape_start = (state == SH_START);
  assign swap_req    = (state == SWAP);
  assign frame_done  = (state == SWAP) && swap_ack;
  assign shape_idx   = idx;

  fb_write_mux #(
    .ADDR_W(BUFFER_ADDR_WIDTH)
  ) u_fb_write_mux (
    .clk              (clk),
    .rst              (rst),
    .src              (owner_of(state)),
    .bg_write_en      (bg_write_en),
    .bg_write_addr    (bg_write_addr),
    .bg_write_data    (bg_write_data),
    .shape_write_en   (shape_write_en),
    .shape_write_addr (shape_write_addr),
    .shape_write_data (shape_write_data),
    .fb_write_en      (fb_write_en),
    .fb_write_addr    (fb_write_addr),
    .fb_write_data    (fb_write_data)
  );

`ifdef FRAME_OVERRUN_COUNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 16'd0;
    end else if (frame_start && busy && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - scoreboard bench for frame_draw_scheduler
module tb_frame_draw_scheduler;
  import types_pkg::*;

  localparam int AW = 15;
  localparam int CW = 5;
  localparam int IW = 4;
`ifdef FRAME_OVERRUN_COUNT_EN
  localparam int EXP_OVR = 3;
`else
  localparam int EXP_OVR = 0;
`endif

  localparam int EV_BG    = 0;
  localparam int EV_SH    = 1;
  localparam int EV_WR    = 2;
  localparam int EV_SWREQ = 3;
  localparam int EV_DONE  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [CW-1:0] shape_count;
  logic          busy, frame_done, bg_start, bg_done;
  logic          bg_write_en;
  logic [AW-1:0] bg_write_addr;
  color_t        bg_write_data;
  logic          shape_start, shape_done;
  logic [IW-1:0] shape_idx;
  logic          shape_write_en;
  logic [AW-1:0] shape_write_addr;
  color_t        shape_write_data;
  logic          fb_write_en;
  logic [AW-1:0] fb_write_addr;
  color_t        fb_write_data;
  logic          swap_req, swap_ack;
  logic [15:0]   overrun_count;

  frame_draw_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .shape_count(shape_count),
    .busy(busy), .frame_done(frame_done), .bg_start(bg_start), .bg_done(bg_done),
    .bg_write_en(bg_write_en), .bg_write_addr(bg_write_addr), .bg_write_data(bg_write_data),
    .shape_start(shape_start), .shape_idx(shape_idx), .shape_done(shape_done),
    .shape_write_en(shape_write_en), .shape_write_addr(shape_write_addr),
    .shape_write_data(shape_write_data), .fb_write_en(fb_write_en),
    .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int val;
    int data;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_swap = 1'b0;

  task automatic push(input int kind, input int val, input int data, input int at);
    ev_t e;
    e.kind = kind; e.val = val; e.data = data; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val, input int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d data=%0h at cycle %0d, required none",
               kind, val, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.data != data || (e.at >= 0 && e.at != cyc)) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d data=%0h cycle=%0d, required kind=%0d val=%0d data=%0h cycle=%0d",
                 kind, val, data, cyc, e.kind, e.val, e.data, e.at);
      end
    end
  endtask

  // Monitor: every DUT output event is popped against the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bg_start)    observe(EV_BG, 0, 0);
      if (shape_start) observe(EV_SH, int'(shape_idx), 0);
      if (fb_write_en) observe(EV_WR, int'(fb_write_addr), int'(fb_write_data));
      if (swap_req && !prev_swap) observe(EV_SWREQ, 0, 0);
      if (frame_done)  observe(EV_DONE, 0, 0);
    end
    prev_swap = (rst === 1'b0) ? swap_req : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bg_start;
      1:       return shape_start;
      default: return swap_req;
    endcase
  endfunction

  task automatic wait_out(input int which, input string name);
    int n;
    n = 0;
    while (sig(which) !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (sig(which) !== 1'b1) begin
      errors++;
      $display("FAIL timeout_%s: got no assertion in 300 cycles, required one", name);
    end
  endtask

  task automatic finish_swap();
    wait_out(2, "swap_req");
    steps(2);
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    steps(2);
  endtask

  // Full frame: count_in requested, n_exp shapes expected, n_over frame_start
  // pulses injected while busy.
  task automatic run_frame(input int count_in, input int n_exp, input int n_over);
    shape_count = CW'(count_in);
    frame_start = 1'b1;
    push(EV_BG, 0, 0, -1);
    for (int i = 0; i < n_exp; i++) push(EV_SH, i, 0, -1);
    push(EV_SWREQ, 0, 0, -1);
    push(EV_DONE, 0, 0, -1);
    step();
    frame_start = 1'b0;
    wait_out(0, "bg_start");
    step();
    for (int j = 0; j < n_over; j++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
    end
    steps(3);
    bg_done = 1'b1;
    step();
    bg_done = 1'b0;
    for (int i = 0; i < n_exp; i++) begin
      wait_out(1, "shape_start");
      steps(5);
      shape_done = 1'b1;
      step();
      shape_done = 1'b0;
    end
    finish_swap();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; frame_start = 1'b0; shape_count = '0; bg_done = 1'b0; shape_done = 1'b0;
    bg_write_en = 1'b0; bg_write_addr = '0; bg_write_data = '0;
    shape_write_en = 1'b0; shape_write_addr = '0; shape_write_data = '0; swap_ack = 1'b0;
    steps(3);
    rst = 1'b0;
    step();
    chk("reset_busy", busy, 0);
    chk("reset_swap_req", swap_req, 0);
    chk("reset_fb_write_en", fb_write_en, 0);
    chk("reset_fb_write_addr", fb_write_addr, 0);
    chk("reset_shape_idx", shape_idx, 0);
    chk("reset_overrun", overrun_count, 0);

    // 1: no shapes, exact cycle timing
    shape_count = '0;
    frame_start = 1'b1;
    c0 = cyc;
    push(EV_BG, 0, 0, c0 + 1);
    push(EV_SWREQ, 0, 0, c0 + 22);
    push(EV_DONE, 0, 0, c0 + 25);
    step();
    frame_start = 1'b0;
    while (cyc < c0 + 20) step();
    bg_done = 1'b1;
    step();
    bg_done = 1'b0;
    chk("t1_drain_busy", busy, 1);
    chk("t1_drain_no_swap", swap_req, 0);
    while (cyc < c0 + 25) step();
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_swap_req", swap_req, 0);
    steps(2);

    // 2: three shapes in order
    run_frame(3, 3, 0);

    // 3: bg writes including one coinciding with bg_done
    shape_count = '0;
    frame_start = 1'b1;
    push(EV_BG, 0, 0, -1);
    push(EV_WR, 42, 16'h0F0F, -1);
    push(EV_WR, 19199, 16'h055F, -1);
    push(EV_SWREQ, 0, 0, -1);
    push(EV_DONE, 0, 0, -1);
    step();
    frame_start = 1'b0;
    bg_write_en = 1'b1; bg_write_addr = AW'(42); bg_write_data = 16'h0F0F;
    step();
    bg_write_en = 1'b0;
    steps(2);
    bg_write_en = 1'b1; bg_write_addr = AW'(19199); bg_write_data = 16'h055F;
    bg_done = 1'b1;
    step();
    bg_write_en = 1'b0; bg_done = 1'b0;
    finish_swap();
    chk("t3_hold_en", fb_write_en, 0);
    chk("t3_hold_addr", fb_write_addr, 19199);
    chk("t3_hold_data", fb_write_data, 16'h055F);

    // 4: non-owner writes dropped, owner write forwarded
    shape_count = CW'(1);
    frame_start = 1'b1;
    push(EV_BG, 0, 0, -1);
    push(EV_SH, 0, 0, -1);
    push(EV_WR, 100, 16'hABCD, -1);
    push(EV_SWREQ, 0, 0, -1);
    push(EV_DONE, 0, 0, -1);
    step();
    frame_start = 1'b0;
    step();
    shape_write_en = 1'b1; shape_write_addr = AW'(7); shape_write_data = 16'h7777;
    step();
    shape_write_en = 1'b0;
    step();
    bg_done = 1'b1;
    step();
    bg_done = 1'b0;
    wait_out(1, "shape_start");
    step();
    bg_write_en = 1'b1; bg_write_addr = AW'(9); bg_write_data = 16'h9999;
    step();
    bg_write_en = 1'b0;
    shape_write_en = 1'b1; shape_write_addr = AW'(100); shape_write_data = 16'hABCD;
    step();
    shape_write_en = 1'b0;
    steps(2);
    shape_done = 1'b1;
    step();
    shape_done = 1'b0;
    finish_swap();

    // 5: clamp to 16 shapes, three dropped frame_starts
    run_frame(20, 16, 3);
    chk("t5_overrun", overrun_count, EXP_OVR);

    // 6: reset during the third shape
    shape_count = CW'(4);
    frame_start = 1'b1;
    push(EV_BG, 0, 0, -1);
    push(EV_SH, 0, 0, -1);
    push(EV_SH, 1, 0, -1);
    push(EV_SH, 2, 0, -1);
    step();
    frame_start = 1'b0;
    step();
    bg_done = 1'b1;
    step();
    bg_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_out(1, "shape_start");
      if (i < 2) begin
        steps(2);
        shape_done = 1'b1;
        step();
        shape_done = 1'b0;
      end
    end
    step();
    chk("t6_pre_idx", shape_idx, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_shape_start", shape_start, 0);
    chk("t6_swap_req", swap_req, 0);
    chk("t6_fb_addr", fb_write_addr, 0);
    chk("t6_shape_idx", shape_idx, 0);
    chk("t6_overrun", overrun_count, 0);
    shape_done = 1'b1;
    shape_write_en = 1'b1; shape_write_addr = AW'(55); shape_write_data = 16'h5555;
    step();
    shape_done = 1'b0; shape_write_en = 1'b0;
    steps(3);
    chk("t6_still_idle", busy, 0);
    run_frame(1, 1, 0);

    steps(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
